// File: rtl/online_div_pkg.sv
// Shared phase codes and FSM encoding for the online-division sequencer.
package online_div_pkg;

  // Phase codes presented to the w-value datapath on STATE.
  localparam logic [1:0] ST_IDLE_WAIT = 2'b00;
  localparam logic [1:0] ST_ADD       = 2'b01;
  localparam logic [1:0] ST_SHIFT     = 2'b11;
  localparam logic [1:0] ST_DRAIN     = 2'b10;

  // Internal sequencer states; IDLE and WAIT share the same phase code.
  typedef enum logic [2:0] {
    FSM_IDLE  = 3'd0,
    FSM_WAIT  = 3'd1,
    FSM_ADD   = 3'd2,
    FSM_SHIFT = 3'd3,
    FSM_DRAIN = 3'd4
  } fsm_state_e;

  // Map an internal state onto the datapath phase code.
  function automatic logic [1:0] phase_code(input fsm_state_e s);
    case (s)
      FSM_ADD:   return ST_ADD;
      FSM_SHIFT: return ST_SHIFT;
      FSM_DRAIN: return ST_DRAIN;
      default:   return ST_IDLE_WAIT;
    endcase
  endfunction

endpackage

// File: rtl/online_div_seq_ctrl.sv
// Per-digit sequencer for the online-division residue datapath: sweeps the
// residue RAM up during ADD, strobes SHIFT, sweeps down during DRAIN, then
// latches the quotient digit and either waits for the next operand or ends.
module online_div_seq_ctrl
  import online_div_pkg::*;
#(
  parameter int NUM_WORDS = 8,
  parameter int CW        = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] n_digits,
  input  logic          abort,
  input  logic          operand_valid,
  output logic          operand_ack,
  output logic [1:0]    STATE,
  output logic [CW-1:0] computation_cycle,
  output logic          carry_feedback,
  output logic          carry_propogate,
  output logic          sel_en,
  output logic [CW-1:0] digit_index,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] LAST_WORD = CW'(NUM_WORDS - 1);

  fsm_state_e    state_q, state_d;
  logic [CW-1:0] n_latched_q, n_latched_d;
  logic [CW-1:0] digit_index_q, digit_index_d;
  logic [CW-1:0] cc_q, cc_d;
  logic [1:0]    phase_q, phase_d;
  logic          ack_q, ack_d;
  logic          cf_q, cf_d;
  logic          cp_q, cp_d;
  logic          sel_en_q, sel_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state and next-output decode; every output is the flop of its _d.
  always_comb begin
    state_d       = state_q;
    n_latched_d   = n_latched_q;
    digit_index_d = digit_index_q;
    cc_d          = cc_q;
    busy_d        = busy_q;
    ack_d         = 1'b0;
    cf_d          = 1'b0;
    cp_d          = 1'b0;
    sel_en_d      = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      FSM_IDLE: begin
        if (start) begin
          if (n_digits != '0) begin
            n_latched_d   = n_digits;
            digit_index_d = '0;
            cc_d          = '0;
            busy_d        = 1'b1;
            state_d       = FSM_WAIT;
          end else begin
            // Zero-length division completes immediately without going busy.
            done_d = 1'b1;
          end
        end
      end
      FSM_WAIT: begin
        if (operand_valid) begin
          ack_d   = 1'b1;
          cf_d    = 1'b1;
          cc_d    = '0;
          state_d = FSM_ADD;
        end
      end
      FSM_ADD: begin
        if (cc_q == LAST_WORD) begin
          cp_d    = 1'b1;
          state_d = FSM_SHIFT;
        end else begin
          cc_d = cc_q + CW'(1);
        end
      end
      FSM_SHIFT: begin
        // Word address holds at the top word so DRAIN starts from there.
        state_d = FSM_DRAIN;
      end
      FSM_DRAIN: begin
        if (cc_q == '0) begin
          sel_en_d = 1'b1;
          if (digit_index_q == n_latched_q - CW'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FSM_IDLE;
          end else begin
            digit_index_d = digit_index_q + CW'(1);
            state_d       = FSM_WAIT;
          end
        end else begin
          cc_d = cc_q - CW'(1);
        end
      end
      default: begin
        state_d = FSM_IDLE;
      end
    endcase

    // Cancel beats any same-cycle operand acceptance or digit completion.
    if (abort && (state_q != FSM_IDLE)) begin
      state_d       = FSM_IDLE;
      n_latched_d   = '0;
      digit_index_d = '0;
      cc_d          = '0;
      busy_d        = 1'b0;
      ack_d         = 1'b0;
      cf_d          = 1'b0;
      cp_d          = 1'b0;
      sel_en_d      = 1'b0;
      done_d        = 1'b0;
    end

    phase_d = phase_code(state_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FSM_IDLE;
      n_latched_q   <= '0;
      digit_index_q <= '0;
      cc_q          <= '0;
      phase_q       <= ST_IDLE_WAIT;
      ack_q         <= 1'b0;
      cf_q          <= 1'b0;
      cp_q          <= 1'b0;
      sel_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_latched_q   <= n_latched_d;
      digit_index_q <= digit_index_d;
      cc_q          <= cc_d;
      phase_q       <= phase_d;
      ack_q         <= ack_d;
      cf_q          <= cf_d;
      cp_q          <= cp_d;
      sel_en_q      <= sel_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign operand_ack       = ack_q;
  assign STATE             = phase_q;
  assign computation_cycle = cc_q;
  assign carry_feedback    = cf_q;
  assign carry_propogate   = cp_q;
  assign sel_en            = sel_en_q;
  assign digit_index       = digit_index_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_online_div_seq_ctrl.sv
// Randomized scoreboard bench for the online-division sequencer.
module tb_online_div_seq_ctrl;

  localparam int NW = 8;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] n_digits = '0;
  logic          abort = 1'b0;
  logic          operand_valid = 1'b0;
  logic          operand_ack;
  logic [1:0]    STATE;
  logic [CW-1:0] computation_cycle;
  logic          carry_feedback;
  logic          carry_propogate;
  logic          sel_en;
  logic [CW-1:0] digit_index;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  online_div_seq_ctrl #(.NUM_WORDS(NW), .CW(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .n_digits         (n_digits),
    .abort            (abort),
    .operand_valid    (operand_valid),
    .operand_ack      (operand_ack),
    .STATE            (STATE),
    .computation_cycle(computation_cycle),
    .carry_feedback   (carry_feedback),
    .carry_propogate  (carry_propogate),
    .sel_en           (sel_en),
    .digit_index      (digit_index),
    .busy             (busy),
    .done             (done)
  );

  // One entry per expected quotient digit.
  typedef struct {
    int idx;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ov_mode = 0;   // 0: always valid, 1: random, 2: driven by hand

  // ---------------------------------------------------------------------
  // Monitor: a timing reference built from the digit schedule (offset k
  // counted from operand_ack: k<NW ADD, k==NW SHIFT, then DRAIN counting
  // down, sel_en at k==2*NW+1) plus a scoreboard of expected digits.
  // ---------------------------------------------------------------------
  initial begin
    int  mode;        // 0 idle, 1 waiting for operand, 2 computing a digit
    int  k;
    bit  sel_exp, done_exp, armed, lst;
    logic [1:0]    e_st;
    logic [CW-1:0] e_cc;
    logic          e_cf, e_cp, e_ack, e_busy;
    exp_t          ent;
    mode = 0; k = 0; sel_exp = 0; done_exp = 0; armed = 0;
    forever begin
      @(negedge clk);
      if (armed) begin
        e_st = 2'b00; e_cc = '0; e_cf = 0; e_cp = 0; e_ack = 0;
        e_busy = (mode != 0);
        if (mode == 2) begin
          if (k < NW) begin
            e_st = 2'b01; e_cc = CW'(k); e_cf = (k == 0); e_ack = (k == 0);
          end else if (k == NW) begin
            e_st = 2'b11; e_cc = CW'(NW - 1); e_cp = 1'b1;
          end else begin
            e_st = 2'b10; e_cc = CW'(2 * NW - k);
          end
        end
        checks++;
        if ({STATE, computation_cycle, carry_feedback, carry_propogate, operand_ack, sel_en, busy, done}
            !== {e_st, e_cc, e_cf, e_cp, e_ack, sel_exp, e_busy, done_exp}) begin
          errors++;
          $display("FAIL outputs t=%0t got STATE=%b cc=%0d cf=%b cp=%b ack=%b sel=%b busy=%b done=%b want STATE=%b cc=%0d cf=%b cp=%b ack=%b sel=%b busy=%b done=%b",
                   $time, STATE, computation_cycle, carry_feedback, carry_propogate, operand_ack, sel_en, busy, done,
                   e_st, e_cc, e_cf, e_cp, e_ack, sel_exp, e_busy, done_exp);
        end
        if (mode == 2 && k == 0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ack_index t=%0t got digit_index=%0d want no digit in progress", $time, digit_index);
          end else if (digit_index !== CW'(exp_q[0].idx)) begin
            errors++;
            $display("FAIL ack_index t=%0t got digit_index=%0d want %0d", $time, digit_index, exp_q[0].idx);
          end
        end
        if (sel_en === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sel_pop t=%0t got sel_en with empty scoreboard want none", $time);
          end else begin
            ent = exp_q.pop_front();
            if (done !== ent.last) begin
              errors++;
              $display("FAIL digit_done t=%0t digit %0d got done=%b want %b", $time, ent.idx, done, ent.last);
            end
            $display("digit %0d selected at t=%0t done=%b", ent.idx, $time, done);
          end
        end else if (done === 1'b1) begin
          $display("zero-length division done at t=%0t", $time);
        end
      end

      // advance the reference to the next cycle
      sel_exp = 0;
      done_exp = 0;
      if (rst) begin
        armed = 1;
        mode = 0;
        exp_q.delete();
      end else if (abort && mode != 0) begin
        mode = 0;
        exp_q.delete();
      end else begin
        case (mode)
          0: if (start) begin
               if (n_digits != '0) mode = 1;
               else done_exp = 1;
             end
          1: if (operand_valid) begin
               mode = 2;
               k = 0;
             end
          default: begin
            if (k < 2 * NW) begin
              k++;
            end else begin
              lst = (exp_q.size() == 0) ? 1'b1 : exp_q[0].last;
              sel_exp = 1;
              if (lst) begin
                done_exp = 1;
                mode = 0;
              end else begin
                mode = 1;
              end
            end
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (ov_mode == 0) operand_valid = 1'b1;
    else if (ov_mode == 1) operand_valid = (($urandom % 4) != 0);
  endtask

  task automatic push_digits(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.idx = i;
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue_start(input int n);
    push_digits(n);
    start = 1'b1;
    n_digits = CW'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (busy === 1'b1 && cnt < 3000) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt >= 3000) begin
      errors++;
      $display("FAIL idle_timeout t=%0t got busy=%b want 0 within 3000 cycles", $time, busy);
    end
  endtask

  task automatic wait_ack_idx(input int idx);
    int cnt = 0;
    while (!(operand_ack === 1'b1 && digit_index == CW'(idx)) && cnt < 500) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt >= 500) begin
      errors++;
      $display("FAIL ack_timeout t=%0t got no ack for digit %0d want ack", $time, idx);
    end
  endtask

  task automatic wait_sel();
    int cnt = 0;
    while (sel_en !== 1'b1 && cnt < 500) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt >= 500) begin
      errors++;
      $display("FAIL sel_timeout t=%0t got sel_en=%b want 1", $time, sel_en);
    end
  endtask

  initial begin
    int n, r;
    // reset held three cycles
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // single digit, operand always valid
    ov_mode = 0;
    issue_start(1);
    wait_idle();
    tick();

    // three digits back to back
    issue_start(3);
    wait_idle();
    tick();

    // two digits with the operand withheld after digit 0
    ov_mode = 2;
    operand_valid = 1'b1;
    issue_start(2);
    wait_ack_idx(0);
    operand_valid = 1'b0;
    wait_sel();
    repeat (4) tick();
    operand_valid = 1'b1;
    wait_idle();
    ov_mode = 0;
    tick();

    // abort at word 3 of ADD on digit 1, then a clean run
    issue_start(3);
    wait_ack_idx(1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle();
    tick();
    issue_start(2);
    wait_idle();
    tick();

    // zero-length start, then a start ignored while busy
    issue_start(0);
    issue_start(2);
    repeat (5) tick();
    start = 1'b1;
    n_digits = CW'(5);
    tick();
    start = 1'b0;
    wait_idle();
    tick();

    // reset mid-operation dominates abort and start
    issue_start(2);
    repeat (10) tick();
    rst = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    wait_idle();
    tick();

    // randomized divisions with random operand gaps, stray starts, aborts
    ov_mode = 1;
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, 5);
      issue_start(n);
      if (($urandom % 3) == 0) begin
        repeat ($urandom_range(1, 20)) tick();
        if (busy === 1'b1) begin
          start = 1'b1;
          n_digits = CW'($urandom_range(1, 9));
          tick();
          start = 1'b0;
        end
      end
      if (($urandom % 4) == 0) begin
        r = $urandom_range(2, 60);
        for (int c = 0; c < r && busy === 1'b1; c++) tick();
        if (busy === 1'b1) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
        end
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end
    ov_mode = 0;
    repeat (3) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending digits want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog t=%0t got still running want finished", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
